// File: rtl/param_readback_tx_pkg.sv
// Shared constants, frame layout offsets, FSM state type and CRC-8 step for the
// parameter readback serializer.
package readback_pkg;

    localparam logic [7:0] HEADER_BYTE = 8'hA5;
    localparam int         FRAME_LEN   = 23;
    localparam int         PAYLOAD_LEN = 21;

    // Byte offsets within the frame; multi-byte fields are little-endian
    localparam int OFF_PER      = 1;
    localparam int OFF_P1WID    = 5;
    localparam int OFF_DEL      = 9;
    localparam int OFF_P2WID    = 13;
    localparam int OFF_CP       = 17;
    localparam int OFF_P_BL     = 18;
    localparam int OFF_P_BL_OFF = 19;
    localparam int OFF_FLAGS    = 21;
    localparam int OFF_CHECK    = 22;

    localparam logic [7:0] CRC_POLY = 8'h07;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_FINISH
    } state_t;

    // One byte of MSB-first CRC-8, no reflection
    function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/param_readback_tx_if.sv
// Request/status handshake plus the live pulse parameter set seen by the
// readback serializer.
interface param_readback_tx_if;
    logic        req;
    logic [31:0] per;
    logic [31:0] p1wid;
    logic [31:0] del;
    logic [31:0] p2wid;
    logic [7:0]  cp;
    logic [7:0]  p_bl;
    logic [15:0] p_bl_off;
    logic        pu;
    logic        bl;
    logic        busy;
    logic        done;

    modport master (
        output req, per, p1wid, del, p2wid, cp, p_bl, p_bl_off, pu, bl,
        input  busy, done
    );

    modport slave (
        input  req, per, p1wid, del, p2wid, cp, p_bl, p_bl_off, pu, bl,
        output busy, done
    );
endinterface

// File: rtl/param_readback_tx_uart_tx_byte.sv
// 8N1 byte transmitter; ready rises in the last stop-bit cycle so a new start
// bit can follow with no idle gap.
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready
);
    localparam int              CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] baud_cnt_reg;
    logic [3:0]    bit_cnt_reg;
    logic [7:0]    data_reg;
    logic          active_reg;
    logic          tx_reg;
    logic          bit_end;

    assign bit_end = (baud_cnt_reg == BAUD_LAST);
    assign ready   = !active_reg || (bit_end && bit_cnt_reg == 4'd9);
    assign tx      = tx_reg;

    // bit_cnt 0 is the start bit, 1..8 data LSB first, 9 the stop bit
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            data_reg     <= '0;
            active_reg   <= 1'b0;
            tx_reg       <= 1'b1;
        end else if (start && ready) begin
            data_reg     <= data;
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            active_reg   <= 1'b1;
            tx_reg       <= 1'b0;
        end else if (active_reg) begin
            if (bit_end) begin
                baud_cnt_reg <= '0;
                if (bit_cnt_reg == 4'd9) begin
                    active_reg <= 1'b0;
                    tx_reg     <= 1'b1;
                end else begin
                    bit_cnt_reg <= bit_cnt_reg + 4'd1;
                    tx_reg      <= (bit_cnt_reg == 4'd8) ? 1'b1 : data_reg[bit_cnt_reg[2:0]];
                end
            end else begin
                baud_cnt_reg <= baud_cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/param_readback_tx.sv
// Snapshots the pulse parameter set and sends it as a 23-byte UART frame.
// Define READBACK_CRC8_EN to replace the XOR check byte with CRC-8 (poly 0x07).
module param_readback_tx
    import readback_pkg::*;
#(
    parameter int CLK_HZ = 12000000,
    parameter int BAUD   = 115200
) (
    input  logic                 clk,
    input  logic                 resetn,
    param_readback_tx_if.slave   bus,
    output logic                 RS232_Tx
);
    localparam int CLKS_PER_BIT = (CLK_HZ + BAUD / 2) / BAUD;

    logic [PAYLOAD_LEN*8-1:0] payload_in;
    logic [7:0]               payload_bytes [PAYLOAD_LEN];
    logic [7:0]               payload_reg   [PAYLOAD_LEN];

    state_t     state_reg, state_next;
    logic [4:0] idx_reg, idx_next;
    logic [7:0] check_reg, check_next;
    logic [7:0] check_upd;
    logic [4:0] payload_sel;
    logic [7:0] cur_byte;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_ready;

    // Little-endian packing: bit 0 of payload_in is bit 0 of frame byte 1
    assign payload_in = {6'b0, bus.bl, bus.pu, bus.p_bl_off, bus.p_bl, bus.cp,
                         bus.p2wid, bus.del, bus.p1wid, bus.per};

    for (genvar gi = 0; gi < PAYLOAD_LEN; gi++) begin : g_payload
        assign payload_bytes[gi] = payload_in[gi*8 +: 8];
    end

    always_ff @(posedge clk) begin
        if (state_reg == ST_LOAD) begin
            payload_reg <= payload_bytes;
        end
    end

    assign payload_sel = idx_reg - 5'd1;
    assign cur_byte    = (idx_reg == 5'(OFF_CHECK)) ? check_reg : payload_reg[payload_sel];

`ifdef READBACK_CRC8_EN
    assign check_upd = crc8_update(check_reg, cur_byte);
`else
    assign check_upd = check_reg ^ cur_byte;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= ST_IDLE;
            idx_reg   <= '0;
            check_reg <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            check_reg <= check_next;
        end
    end

    // The header goes out straight from LOAD so the start bit lands one cycle later
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        check_next = check_reg;
        tx_start   = 1'b0;
        tx_data    = HEADER_BYTE;
        case (state_reg)
            ST_IDLE: begin
                if (bus.req) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                tx_start   = 1'b1;
                tx_data    = HEADER_BYTE;
                idx_next   = 5'd1;
                check_next = 8'h00;
                state_next = ST_SEND;
            end
            ST_SEND: begin
                if (tx_ready) begin
                    if (idx_reg == 5'(FRAME_LEN)) begin
                        state_next = ST_FINISH;
                    end else begin
                        tx_start = 1'b1;
                        tx_data  = cur_byte;
                        idx_next = idx_reg + 5'd1;
                        if (idx_reg != 5'(OFF_CHECK)) begin
                            check_next = check_upd;
                        end
                    end
                end
            end
            ST_FINISH: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.busy = (state_reg != ST_IDLE);
    assign bus.done = (state_reg == ST_FINISH);

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk   (clk),
        .resetn(resetn),
        .start (tx_start),
        .data  (tx_data),
        .tx    (RS232_Tx),
        .ready (tx_ready)
    );

endmodule

// File: tb/tb_param_readback_tx.sv
// Bench for param_readback_tx: one default-rate instance for exact 104-cycle
// timing, one fast instance for table, random, lockout and reset-abort frames.
module tb_param_readback_tx;

    localparam int CPB_SLOW = 104;
    localparam int CPB_FAST = 6;

    typedef struct {
        logic [31:0] per;
        logic [31:0] p1wid;
        logic [31:0] del;
        logic [31:0] p2wid;
        logic [7:0]  cp;
        logic [7:0]  p_bl;
        logic [15:0] p_bl_off;
        logic        pu;
        logic        bl;
        int          exp_chk;
    } vec_t;

    logic        clk;
    logic        resetn;
    logic        req_slow, req_fast, sel;
    logic [31:0] per, p1wid, del, p2wid;
    logic [7:0]  cp, p_bl;
    logic [15:0] p_bl_off;
    logic        pu, bl;
    logic        tx_slow, tx_fast;
    logic        mon_tx, mon_busy, mon_done;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          timing_bad = 0;
    int          gap_bad = 0;
    int          done_cnt = 0;
    int          last_end = 0;
    logic [7:0]  rx_q [$];

    param_readback_tx_if bus_slow ();
    param_readback_tx_if bus_fast ();

    assign bus_slow.req = req_slow;
    assign bus_fast.req = req_fast;
    assign bus_slow.per = per;      assign bus_fast.per = per;
    assign bus_slow.p1wid = p1wid;  assign bus_fast.p1wid = p1wid;
    assign bus_slow.del = del;      assign bus_fast.del = del;
    assign bus_slow.p2wid = p2wid;  assign bus_fast.p2wid = p2wid;
    assign bus_slow.cp = cp;        assign bus_fast.cp = cp;
    assign bus_slow.p_bl = p_bl;    assign bus_fast.p_bl = p_bl;
    assign bus_slow.p_bl_off = p_bl_off; assign bus_fast.p_bl_off = p_bl_off;
    assign bus_slow.pu = pu;        assign bus_fast.pu = pu;
    assign bus_slow.bl = bl;        assign bus_fast.bl = bl;

    param_readback_tx dut_slow (
        .clk(clk), .resetn(resetn), .bus(bus_slow), .RS232_Tx(tx_slow)
    );

    param_readback_tx #(.CLK_HZ(12000000), .BAUD(2000000)) dut_fast (
        .clk(clk), .resetn(resetn), .bus(bus_fast), .RS232_Tx(tx_fast)
    );

    assign mon_tx   = sel ? tx_fast : tx_slow;
    assign mon_busy = sel ? bus_fast.busy : bus_slow.busy;
    assign mon_done = sel ? bus_fast.done : bus_slow.done;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (mon_done === 1'b1) done_cnt <= done_cnt + 1;

    // Line decoder: every cycle of a bit cell must hold the same level
    initial begin : line_monitor
        logic [9:0] bits;
        bit bad, aborted;
        int cpb;
        forever begin
            @(negedge clk);
            if (resetn === 1'b1 && mon_tx === 1'b0) begin
                cpb = sel ? CPB_FAST : CPB_SLOW;
                if (rx_q.size() > 0 && cyc != last_end + 1) gap_bad++;
                bad = 0;
                aborted = 0;
                bits = '1;
                for (int b = 0; b < 10 && !aborted; b++) begin
                    for (int c = 0; c < cpb && !aborted; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (resetn !== 1'b1) aborted = 1;
                        else if (c == 0) bits[b] = mon_tx;
                        else if (mon_tx !== bits[b]) bad = 1;
                    end
                end
                if (!aborted) begin
                    if (bits[0] !== 1'b0 || bits[9] !== 1'b1) bad = 1;
                    if (bad) timing_bad++;
                    rx_q.push_back(bits[8:1]);
                    last_end = cyc;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Check byte: plain XOR, or CRC-8 as the remainder of M(x)*x^8 mod x^8+x^2+x+1
    function automatic logic [7:0] model_check(input logic [7:0] fr [23]);
        logic [7:0] acc;
`ifdef READBACK_CRC8_EN
        bit m [176];
        logic [8:0] g;
        g = 9'h107;
        for (int i = 0; i < 168; i++) m[i] = fr[1 + i / 8][7 - i % 8];
        for (int i = 168; i < 176; i++) m[i] = 1'b0;
        for (int i = 0; i < 168; i++)
            if (m[i]) for (int j = 0; j < 9; j++) m[i + j] ^= g[8 - j];
        for (int i = 0; i < 8; i++) acc[7 - i] = m[168 + i];
`else
        acc = 8'h00;
        for (int i = 1; i <= 21; i++) acc ^= fr[i];
`endif
        return acc;
    endfunction

    task automatic model_frame(input vec_t v, output logic [7:0] fr [23]);
        logic [31:0] words [4];
        words = '{v.per, v.p1wid, v.del, v.p2wid};
        fr[0] = 8'hA5;
        for (int w = 0; w < 4; w++)
            for (int k = 0; k < 4; k++)
                fr[1 + 4 * w + k] = 8'((words[w] >> (8 * k)) & 32'hFF);
        fr[17] = v.cp;
        fr[18] = v.p_bl;
        fr[19] = 8'(v.p_bl_off % 256);
        fr[20] = 8'(v.p_bl_off / 256);
        fr[21] = 8'(2 * int'(v.bl) + int'(v.pu));
        fr[22] = model_check(fr);
    endtask

    task automatic apply(input vec_t v);
        per = v.per; p1wid = v.p1wid; del = v.del; p2wid = v.p2wid;
        cp = v.cp; p_bl = v.p_bl; p_bl_off = v.p_bl_off; pu = v.pu; bl = v.bl;
    endtask

    task automatic set_req(input logic val);
        if (sel) req_fast = val;
        else req_slow = val;
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        v.per = $urandom; v.p1wid = $urandom; v.del = $urandom; v.p2wid = $urandom;
        v.cp = 8'($urandom); v.p_bl = 8'($urandom); v.p_bl_off = 16'($urandom);
        v.pu = 1'($urandom); v.bl = 1'($urandom); v.exp_chk = -1;
        return v;
    endfunction

    // One request, optional mid-frame poke (cp change plus a second req), full frame check
    task automatic run_frame(input vec_t v, input logic fast, input int poke_at, input string tag);
        logic [7:0] exp [23];
        int cpb, flen, lat, busy_low, tx_low, done0;
        logic [31:0] got;
        sel = fast;
        cpb = fast ? CPB_FAST : CPB_SLOW;
        flen = 23 * 10 * cpb;
        apply(v);
        model_frame(v, exp);
        @(negedge clk);
        rx_q.delete();
        timing_bad = 0;
        gap_bad = 0;
        done0 = done_cnt;
        set_req(1'b1);
        @(negedge clk);
        set_req(1'b0);
        check({tag, "_busy_load"}, mon_busy, 1);
        check({tag, "_tx_load"}, mon_tx, 1);
        @(negedge clk);
        check({tag, "_start_bit"}, mon_tx, 0);
        lat = 2;
        busy_low = 0;
        while (mon_done !== 1'b1 && lat < flen + 50) begin
            if (mon_busy !== 1'b1) busy_low++;
            if (poke_at > 0 && lat == poke_at) begin
                cp = 8'hFF;
                set_req(1'b1);
            end else if (poke_at > 0 && lat == poke_at + 1) begin
                set_req(1'b0);
            end
            @(negedge clk);
            lat++;
        end
        check({tag, "_done_seen"}, mon_done, 1);
        check({tag, "_done_latency"}, lat, flen + 2);
        check({tag, "_busy_held"}, busy_low, 0);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, mon_done, 0);
        check({tag, "_busy_fall"}, mon_busy, 0);
        tx_low = 0;
        for (int i = 0; i < 25 * cpb; i++) begin
            @(negedge clk);
            if (mon_tx !== 1'b1) tx_low++;
        end
        check({tag, "_quiet_after"}, tx_low, 0);
        check({tag, "_done_count"}, done_cnt - done0, 1);
        check({tag, "_byte_count"}, rx_q.size(), 23);
        for (int i = 0; i < 23; i++) begin
            got = (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hFFFF_FFFF;
            check($sformatf("%s_byte%0d", tag, i), got, 32'(exp[i]));
        end
`ifndef READBACK_CRC8_EN
        if (v.exp_chk >= 0) begin
            got = (rx_q.size() == 23) ? 32'(rx_q[22]) : 32'hFFFF_FFFF;
            check({tag, "_check_table"}, got, v.exp_chk);
        end
`endif
        check({tag, "_cell_timing"}, timing_bad, 0);
        check({tag, "_byte_gap"}, gap_bad, 0);
        $display("frame %s: %0d bytes, check byte 0x%02h, done at +%0d cycles",
                 tag, rx_q.size(), (rx_q.size() == 23) ? rx_q[22] : 8'h00, lat);
    endtask

    initial begin : main
        vec_t vecs [6];
        vec_t v;
        int n;

        vecs[0] = '{32'h01020304, 32'h0, 32'h0, 32'h0, 8'h00, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h04};
        vecs[1] = '{32'h0, 32'h0, 32'h0, 32'h0, 8'h10, 8'h00, 16'h0000, 1'b1, 1'b1, 8'h13};
        vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                    8'hFF, 8'hFF, 16'hFFFF, 1'b1, 1'b1, 8'h03};
        vecs[3] = '{32'h12345678, 32'h9ABCDEF0, 32'h0, 32'h0, 8'h00, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00};
        vecs[4] = '{32'h0, 32'h0, 32'h0, 32'h0, 8'h01, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h01};
        vecs[5] = '{32'h0, 32'h0, 32'h000000C3, 32'h0, 8'h00, 8'h5A, 16'hA55A, 1'b0, 1'b0, 8'h66};

        resetn = 1'b0;
        req_slow = 1'b0;
        req_fast = 1'b0;
        sel = 1'b0;
        apply(vecs[0]);
        @(negedge clk);
        check("reset_tx_slow", tx_slow, 1);
        check("reset_tx_fast", tx_fast, 1);
        check("reset_busy", bus_slow.busy, 0);
        check("reset_done", bus_fast.done, 0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("idle_busy_fast", bus_fast.busy, 0);

        run_frame(vecs[0], 1'b0, 0, "slow_basic");

        for (int i = 0; i < 6; i++)
            run_frame(vecs[i], 1'b1, (i == 1) ? 1000 : 0, $sformatf("vec%0d", i));

        for (int i = 0; i < 6; i++)
            run_frame(rand_vec(), 1'b1, 0, $sformatf("rand%0d", i));

        // Reset during the start bit of byte 7, then a clean frame afterwards
        sel = 1'b1;
        v = rand_vec();
        apply(v);
        rx_q.delete();
        @(negedge clk);
        req_fast = 1'b1;
        @(negedge clk);
        req_fast = 1'b0;
        n = 0;
        while (rx_q.size() < 7 && n < 20 * 10 * CPB_FAST) begin
            @(negedge clk);
            n++;
        end
        check("abort_reach_byte7", rx_q.size(), 7);
        @(negedge clk);
        @(negedge clk);
        check("abort_tx_before", mon_tx, 0);
        resetn = 1'b0;
        #1;
        check("abort_tx_async", mon_tx, 1);
        check("abort_busy_async", mon_busy, 0);
        repeat (5) @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_idle_tx", mon_tx, 1);
        check("abort_idle_busy", mon_busy, 0);
        run_frame(rand_vec(), 1'b1, 0, "after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
